// File: rtl/lfsr_ber_controller.sv
// Sequencer and error accounting for a multiLFSR checker in a link BER test.
// It flushes the checker, acquires lock on the prediction stream, and counts
// words, bit errors and lock losses during the run.
module lfsr_ber_controller #(
  parameter int LOCK_COUNT   = 16,
  parameter int BAD_BITS     = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int CNT_W        = 48
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      test_len,
  input  logic             chk_tvalid,
  input  logic [31:0]      chk_pred,
  input  logic [31:0]      chk_data,
  output logic             chk_tready,
  output logic             checker_resetn,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic [15:0]      relock_cnt
);

  localparam int DATA_W = 32;
  localparam int RUN_W  = 16;

  localparam logic [5:0]       BAD_TH    = 6'(BAD_BITS);
  localparam logic [RUN_W-1:0] LOCK_TH   = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] UNLOCK_TH = RUN_W'(UNLOCK_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_ACQUIRE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               flush_q, flush_d;
  logic               crst_q, crst_d;
  logic               busy_q, busy_d;
  logic               locked_q, locked_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  pred_p1, pred_d;
  logic               vld_p1, vld_d;
  logic [CNT_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]   berr_q, berr_d;
  logic [15:0]        relock_q, relock_d;
  logic [RUN_W-1:0]   good_q, good_d;
  logic [RUN_W-1:0]   bad_q, bad_d;
  logic [5:0]         errs_p0;
  logic               cmp_p0;

  function automatic logic [5:0] popcount32(input logic [DATA_W-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add_cnt(input logic [CNT_W-1:0] a,
                                                   input logic [5:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-5){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc16(input logic [RUN_W-1:0] a);
    return (&a) ? a : a + RUN_W'(1);
  endfunction

  // Stage p0: compare received word against the prediction held from the previous beat
  assign errs_p0 = popcount32(chk_data ^ pred_p1);
  assign cmp_p0  = chk_tvalid & vld_p1;

  assign chk_tready     = 1'b1;
  assign checker_resetn = crst_q & aresetn;
  assign busy           = busy_q;
  assign locked         = locked_q;
  assign done           = done_q;
  assign word_cnt       = word_q;
  assign bit_err_cnt    = berr_q;
  assign relock_cnt     = relock_q;

  // Next-state, counter updates and output decode
  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    crst_d   = 1'b1;
    pred_d   = pred_p1;
    vld_d    = vld_p1;
    word_d   = word_q;
    berr_d   = berr_q;
    relock_d = relock_q;
    good_d   = good_q;
    bad_d    = bad_q;

    if (stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d  = S_FLUSH;
            flush_d  = 1'b0;
            crst_d   = 1'b0;
            vld_d    = 1'b0;
            word_d   = '0;
            berr_d   = '0;
            relock_d = '0;
            good_d   = '0;
            bad_d    = '0;
          end
        end
        S_FLUSH: begin
          if (flush_q) begin
            state_d = S_ACQUIRE;
          end else begin
            flush_d = 1'b1;
            crst_d  = 1'b0;
          end
        end
        S_ACQUIRE: begin
          if (chk_tvalid) begin
            pred_d = chk_pred;
            vld_d  = 1'b1;
          end
          if (cmp_p0) begin
            if (errs_p0 == 6'd0) begin
              good_d = sat_inc16(good_q);
              if (good_d == LOCK_TH) begin
                state_d = S_RUN;
                bad_d   = '0;
              end
            end else begin
              good_d = '0;
            end
          end
        end
        S_RUN: begin
          if (chk_tvalid) begin
            pred_d = chk_pred;
            vld_d  = 1'b1;
          end
          if (cmp_p0) begin
            word_d = sat_add_cnt(word_q, 6'd1);
            berr_d = sat_add_cnt(berr_q, errs_p0);
            bad_d  = (errs_p0 > BAD_TH) ? sat_inc16(bad_q) : '0;
            if ((test_len != 32'd0) && (word_d == CNT_W'(test_len))) begin
              state_d = S_DONE;
            end else if (bad_d == UNLOCK_TH) begin
              state_d  = S_ACQUIRE;
              relock_d = sat_inc16(relock_q);
              good_d   = '0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d   = (state_d == S_FLUSH) || (state_d == S_ACQUIRE) || (state_d == S_RUN);
    locked_d = (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
  end

  // Stage p1: state, prediction pipeline, counters and registered outputs
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      flush_q  <= 1'b0;
      crst_q   <= 1'b1;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      pred_p1  <= '0;
      vld_p1   <= 1'b0;
      word_q   <= '0;
      berr_q   <= '0;
      relock_q <= '0;
      good_q   <= '0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      crst_q   <= crst_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
      done_q   <= done_d;
      pred_p1  <= pred_d;
      vld_p1   <= vld_d;
      word_q   <= word_d;
      berr_q   <= berr_d;
      relock_q <= relock_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
    end
  end

endmodule
